stage_3_ex: RTL
===============

Name: stage_3_ex

Overview:
- Execute stage of the 5-stage in-order pipeline, directly downstream of stage_2_ID.
- Latches the 117-bit ID→EX bus plus the store data, evaluates the ALU, and issues the data-SRAM request in the cycle the instruction hands off to the memory stage.
- Produces the 71-bit EX→MEM bus and the EX-stage destination address used by the ID hazard check.

Parameters:
- STAGE_2_TO_3_W, 117, width of the incoming ID→EX bus.
- STAGE_3_TO_4_W, 71, width of the outgoing EX→MEM bus.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- valid_2  input  1  ID holds a valid instruction this cycle (already 0 on an ID hazard stall).
- allow_3  output  1  EX can accept a new instruction this cycle.
- valid_3  output  1  EX holds a valid instruction.
- allow_4  input  1  MEM can accept an instruction this cycle.
- stage_2_to_3  input  117  {rf_we[116], dest[115:111], res_from_mem[110], alu_src1[109:78], alu_src2[77:46], alu_op[45:34], mem_we[33], mem_en[32], pc[31:0]}.
- memory_write_data  input  32  store data, combinational from ID; captured together with the bus.
- stage_3_to_4  output  71  {rf_we[70], dest[69:65], res_from_mem[64], alu_result[63:32], pc[31:0]}.
- rf_waddr_3_fwd  output  5  dest when valid_3 && rf_we, else 0.
- data_sram_en  output  1  data SRAM enable.
- data_sram_we  output  4  byte write enables.
- data_sram_addr  output  32  byte address.
- data_sram_wdata  output  32  write data.

Behaviour:
- Reset (async, active-high): valid_3_r=0, bus register=0, wdata register=0. Outputs during and after reset until the first load: valid_3=0, allow_3=1, stage_3_to_4=0, rf_waddr_3_fwd=0, data_sram_en=0, data_sram_we=0.
- readygo_3=1 (single-cycle ALU).
- allow_3 = ~valid_3_r | (readygo_3 & allow_4).
- On each clk edge, if allow_3: valid_3_r<=valid_2.
- If valid_2 && allow_3, the bus register and the wdata register are loaded. Otherwise both hold.
- Bubble (valid_2=0) while allow_3=1: valid_3_r clears and the payload registers are not written.
- Stall (valid_3_r=1, allow_4=0): all registers hold, allow_3=0, no SRAM request.
- A stalled instruction must not issue twice.
- ALU op is one-hot:
  - bit0 add, bit1 sub, bit2 slt (signed), bit3 sltu.
  - bit4 and, bit5 nor, bit6 or, bit7 xor.
  - bit8 sll, bit9 srl, bit10 sra (shift amount = src2[4:0]).
  - bit11 lui (result=src2).
  - All arithmetic is 32-bit and wraps; no overflow flag.
  - alu_op=0 gives result 0.
- SRAM request issue: data_sram_en = valid_3_r & mem_en & allow_4, so the synchronous read data returns in the cycle the instruction sits in MEM.
  - data_sram_we = {4{valid_3_r & mem_we & allow_4}}.
  - data_sram_addr = alu_result.
  - data_sram_wdata = latched memory_write_data.
- stage_3_to_4 is combinational from the registers and the ALU. MEM qualifies it with valid_3.
- rf_waddr_3_fwd is forced to 0 when ~valid_3_r or ~rf_we, so a dest of 0 never reports a hazard.
- Simultaneous handoff and accept (valid_3_r=1, allow_4=1, valid_2=1): the old instruction leaves and the new one loads on the same edge, with no bubble.
- Reset asserted mid-stall: the stage empties immediately and no SRAM enable is produced while reset=1.

Decomposition:
- Shared package: bus width constants and the field bit positions of stage_2_to_3 and stage_3_to_4; ALU op bit indices (ALU_ADD=0 … ALU_LUI=11).
- One sub-module: ex_alu (purely combinational; alu_op, src1, src2 → result).
- Handshake and pipeline registers stay in stage_3_ex.

Test Plan:
- Reset release, then valid_2=1 carrying add with src1=0x7FFFFFFF, src2=1, rf_we=1, dest=5 → next cycle valid_3=1, alu_result=0x80000000, rf_waddr_3_fwd=5, data_sram_en=0.
- st.w with src1=0x1000, src2=0x8, memory_write_data=0xDEADBEEF, allow_4=1 → data_sram_en=1, we=4'hF, addr=0x1008, wdata=0xDEADBEEF for exactly one cycle.
- ld.w in EX with allow_4=0 held for 3 cycles → data_sram_en=0 and allow_3=0 throughout. When allow_4 rises → en=1, we=0, addr correct for one cycle; the next ID instruction loads on that same edge.
- Back-to-back sra src1=0x80000000, src2=4 then sltu src1=1, src2=0xFFFFFFFF with continuous valid_2 → results 0xF8000000 then 1 on consecutive cycles, no bubble.
- Bubble: valid_2=0 for one cycle after an rf_we=1, dest=7 instruction → valid_3=0 and rf_waddr_3_fwd=0 that cycle; an instruction with rf_we=0, dest=9 → fwd=0.
- Async reset pulse mid-cycle while a store is stalled → valid_3, data_sram_en and rf_waddr_3_fwd go to 0 without waiting for clk; after release the store does not issue.

Source files
------------

// File: rtl/stage_3_ex_pkg.sv
// rtl/stage_3_ex_pkg.sv - bus widths, field positions and ALU op indices for the EX stage
package stage_3_ex_pkg;

  localparam int STAGE_2_TO_3_W = 117;
  localparam int STAGE_3_TO_4_W = 71;
  localparam int ALU_OP_W       = 12;

  localparam int S23_RF_WE    = 116;
  localparam int S23_DEST_LSB = 111;
  localparam int S23_RFM      = 110;
  localparam int S23_SRC1_LSB = 78;
  localparam int S23_SRC2_LSB = 46;
  localparam int S23_OP_LSB   = 34;
  localparam int S23_MEM_WE   = 33;
  localparam int S23_MEM_EN   = 32;
  localparam int S23_PC_LSB   = 0;

  localparam int S34_RF_WE    = 70;
  localparam int S34_DEST_LSB = 65;
  localparam int S34_RFM      = 64;
  localparam int S34_RES_LSB  = 32;
  localparam int S34_PC_LSB   = 0;

  localparam int ALU_ADD  = 0;
  localparam int ALU_SUB  = 1;
  localparam int ALU_SLT  = 2;
  localparam int ALU_SLTU = 3;
  localparam int ALU_AND  = 4;
  localparam int ALU_NOR  = 5;
  localparam int ALU_OR   = 6;
  localparam int ALU_XOR  = 7;
  localparam int ALU_SLL  = 8;
  localparam int ALU_SRL  = 9;
  localparam int ALU_SRA  = 10;
  localparam int ALU_LUI  = 11;

endpackage

// File: rtl/stage_3_ex_if.sv
// rtl/stage_3_ex_if.sv - ID/EX/MEM handshake, pipeline buses and data-SRAM request
interface stage_3_ex_if;
  import stage_3_ex_pkg::*;

  logic                      valid_2;
  logic                      allow_3;
  logic                      valid_3;
  logic                      allow_4;
  logic [STAGE_2_TO_3_W-1:0] stage_2_to_3;
  logic [31:0]               memory_write_data;
  logic [STAGE_3_TO_4_W-1:0] stage_3_to_4;
  logic [4:0]                rf_waddr_3_fwd;
  logic                      data_sram_en;
  logic [3:0]                data_sram_we;
  logic [31:0]               data_sram_addr;
  logic [31:0]               data_sram_wdata;

  modport slave (
    input  valid_2, allow_4, stage_2_to_3, memory_write_data,
    output allow_3, valid_3, stage_3_to_4, rf_waddr_3_fwd,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );

  modport master (
    output valid_2, allow_4, stage_2_to_3, memory_write_data,
    input  allow_3, valid_3, stage_3_to_4, rf_waddr_3_fwd,
           data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata
  );

endinterface

// File: rtl/stage_3_ex_alu.sv
// rtl/stage_3_ex_alu.sv - combinational one-hot ALU; an all-zero op yields zero
module ex_alu
  import stage_3_ex_pkg::*;
(
  input  logic [ALU_OP_W-1:0] alu_op_i,
  input  logic [31:0]         src1_i,
  input  logic [31:0]         src2_i,
  output logic [31:0]         result_o
);

  logic [31:0] add_res;
  logic [31:0] sub_res;
  logic [31:0] slt_res;
  logic [31:0] sltu_res;
  logic [31:0] sll_res;
  logic [31:0] srl_res;
  logic [31:0] sra_res;
  logic [4:0]  shamt;

  assign shamt    = src2_i[4:0];
  assign add_res  = src1_i + src2_i;
  assign sub_res  = src1_i - src2_i;
  assign slt_res  = {31'd0, $signed(src1_i) < $signed(src2_i)};
  assign sltu_res = {31'd0, src1_i < src2_i};
  assign sll_res  = src1_i << shamt;
  assign srl_res  = src1_i >> shamt;
  assign sra_res  = $signed(src1_i) >>> shamt;

  // AND-OR select: each op gates its own result, so no op bit set means zero.
  assign result_o = ({32{alu_op_i[ALU_ADD]}}  & add_res)
                  | ({32{alu_op_i[ALU_SUB]}}  & sub_res)
                  | ({32{alu_op_i[ALU_SLT]}}  & slt_res)
                  | ({32{alu_op_i[ALU_SLTU]}} & sltu_res)
                  | ({32{alu_op_i[ALU_AND]}}  & (src1_i & src2_i))
                  | ({32{alu_op_i[ALU_NOR]}}  & ~(src1_i | src2_i))
                  | ({32{alu_op_i[ALU_OR]}}   & (src1_i | src2_i))
                  | ({32{alu_op_i[ALU_XOR]}}  & (src1_i ^ src2_i))
                  | ({32{alu_op_i[ALU_SLL]}}  & sll_res)
                  | ({32{alu_op_i[ALU_SRL]}}  & srl_res)
                  | ({32{alu_op_i[ALU_SRA]}}  & sra_res)
                  | ({32{alu_op_i[ALU_LUI]}}  & src2_i);

endmodule

// File: rtl/stage_3_ex.sv
// rtl/stage_3_ex.sv - execute stage: latches ID bus, runs ALU, issues data-SRAM request on handoff
module stage_3_ex
  import stage_3_ex_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  stage_3_ex_if.slave   bus_if
);

  logic                      valid_3_q, valid_3_d;
  logic [STAGE_2_TO_3_W-1:0] bus_q, bus_d;
  logic [31:0]               wdata_q, wdata_d;
  logic                      readygo_3;
  logic                      allow_3;
  logic                      handoff;

  logic                rf_we;
  logic [4:0]          dest;
  logic                res_from_mem;
  logic [31:0]         alu_src1;
  logic [31:0]         alu_src2;
  logic [ALU_OP_W-1:0] alu_op;
  logic                mem_we;
  logic                mem_en;
  logic [31:0]         pc;
  logic [31:0]         alu_result;

  assign readygo_3 = 1'b1;
  assign allow_3   = ~valid_3_q | (readygo_3 & bus_if.allow_4);
  assign handoff   = valid_3_q & readygo_3 & bus_if.allow_4;

  always_comb begin
    valid_3_d = valid_3_q;
    bus_d     = bus_q;
    wdata_d   = wdata_q;
    if (allow_3) begin
      valid_3_d = bus_if.valid_2;
      if (bus_if.valid_2) begin
        bus_d   = bus_if.stage_2_to_3;
        wdata_d = bus_if.memory_write_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_3_q <= 1'b0;
      bus_q     <= '0;
      wdata_q   <= '0;
    end else begin
      valid_3_q <= valid_3_d;
      bus_q     <= bus_d;
      wdata_q   <= wdata_d;
    end
  end

  assign rf_we        = bus_q[S23_RF_WE];
  assign dest         = bus_q[S23_DEST_LSB +: 5];
  assign res_from_mem = bus_q[S23_RFM];
  assign alu_src1     = bus_q[S23_SRC1_LSB +: 32];
  assign alu_src2     = bus_q[S23_SRC2_LSB +: 32];
  assign alu_op       = bus_q[S23_OP_LSB +: ALU_OP_W];
  assign mem_we       = bus_q[S23_MEM_WE];
  assign mem_en       = bus_q[S23_MEM_EN];
  assign pc           = bus_q[S23_PC_LSB +: 32];

  ex_alu u_alu (
    .alu_op_i (alu_op),
    .src1_i   (alu_src1),
    .src2_i   (alu_src2),
    .result_o (alu_result)
  );

  assign bus_if.allow_3      = allow_3;
  assign bus_if.valid_3      = valid_3_q;
  assign bus_if.stage_3_to_4 = {rf_we, dest, res_from_mem, alu_result, pc};

  // A zero dest must never look like a hazard, so gate on valid and rf_we.
  assign bus_if.rf_waddr_3_fwd = (valid_3_q & rf_we) ? dest : 5'd0;

  // Request only on the handoff edge so a stalled access is issued exactly once.
  assign bus_if.data_sram_en    = handoff & mem_en;
  assign bus_if.data_sram_we    = {4{handoff & mem_we}};
  assign bus_if.data_sram_addr  = alu_result;
  assign bus_if.data_sram_wdata = wdata_q;

endmodule
